// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int UART_DBIT    = 8;
    localparam int UART_OS      = 16;
    localparam int UART_SB_TICK = 16;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - oversampling UART receive deframer feeding the rx FIFO
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int OS      = UART_OS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            frame_err
);

    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            w_rx_s;
    logic            r_rx_prev;
    uart_state_t     r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_done;
    logic            r_ferr;
    logic [DBIT-1:0] r_dout;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_prev <= 1'b1;
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_b       <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            case (r_state)
                // Edge detect runs every clk so a break (line stuck low) never re-arms.
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == S_BIT) begin
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            r_s <= '0;
                            if (r_n == N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // The word is delivered even on a bad stop bit; frame_err flags it.
                    if (s_tick) begin
                        if (r_s == S_STOP) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_dout  <= r_b;
                            r_ferr  <= ~w_rx_s;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign rx_dout      = r_dout;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

    localparam int DBIT    = 8;
    localparam int OS      = 16;
    localparam int SB_TICK = 16;
    localparam int TICK    = 4;
    localparam int BITCLK  = OS * TICK;
    localparam int LAT_NOM = (OS * (DBIT + 1) + OS / 2) * TICK;

    logic            clk = 1'b0;
    logic            reset;
    logic            rx;
    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_dout;
    logic            frame_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int skew   = 0;
    int tick_n = 0;
    int orphan = 0;

    logic [DBIT:0] obs_q[$];
    int            obs_cyc[$];
    logic [DBIT:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_deframer #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OS(OS)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .frame_err    (frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            obs_q.push_back({frame_err, rx_dout});
            obs_cyc.push_back(cyc);
        end else if (frame_err) begin
            orphan++;
        end
    end

    initial begin
        int gap;
        s_tick = 1'b0;
        forever begin
            gap = TICK + ((tick_n % 33 == 32) ? skew : 0);
            repeat (gap - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
            tick_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DBIT-1:0] d, input logic stop);
        line(1'b0, BITCLK);
        for (int i = 0; i < DBIT; i++) line(d[i], BITCLK);
        line(stop, BITCLK);
        exp_q.push_back({~stop, d});
    endtask

    task automatic drain(input string tag);
        logic [DBIT:0] e;
        logic [DBIT:0] o;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                check(tag, o, e);
            end
        end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        int t0;
        int lat;
        logic [DBIT-1:0] d;
        logic stop;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", rx_done_tick, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_dout", rx_dout, 0);
        reset = 1'b0;
        line(1'b1, 2 * BITCLK);

        t0 = cyc;
        send(8'hA5, 1'b1);
        line(1'b1, BITCLK);
        lat = (obs_cyc.size() > 0) ? obs_cyc[0] - t0 : -1;
        check("a5_latency", (lat >= LAT_NOM - 8 && lat <= LAT_NOM + 16), 1);
        drain("a5");

        line(1'b0, 20);
        line(1'b1, 2 * BITCLK);
        check("glitch_none", obs_q.size(), 0);
        send(8'h3C, 1'b1);
        line(1'b1, BITCLK);
        drain("glitch_3c");

        send(8'h81, 1'b0);
        line(1'b0, 20 * BITCLK);
        drain("ferr_81");
        line(1'b1, 2 * BITCLK);
        check("break_none", obs_q.size(), 0);
        send(8'h96, 1'b1);
        line(1'b1, 3 * BITCLK);
        drain("after_break");
        check("dout_hold", rx_dout, 8'h96);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        line(1'b1, BITCLK);
        drain("b2b");

        d = 8'h5B;
        line(1'b0, BITCLK);
        for (int i = 0; i < 4; i++) line(d[i], BITCLK);
        line(d[4], BITCLK / 2);
        reset = 1'b1;
        #1;
        check("midrst_done", rx_done_tick, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_dout", rx_dout, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        line(1'b1, 12 * BITCLK);
        check("midrst_none", obs_q.size(), 0);
        check("midrst_dout_idle", rx_dout, 0);
        send(8'h7E, 1'b1);
        line(1'b1, BITCLK);
        drain("rst_7e");

        skew = 1;
        send(8'hC3, 1'b1);
        line(1'b1, BITCLK);
        drain("skew_slow");
        skew = -1;
        send(8'hC3, 1'b1);
        line(1'b1, BITCLK);
        drain("skew_fast");
        skew = 0;

        for (int f = 0; f < 8; f++) begin
            d    = DBIT'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send(d, stop);
            line(1'b1, stop ? $urandom_range(0, 40) : $urandom_range(8, 60));
        end
        line(1'b1, BITCLK);
        drain("rand");

        check("orphan_ferr", orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
